// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU and long-latency results onto one regfile port.
// Optional WB_BYPASS_EN: an idle-FIFO long-latency result is written with zero latency.
module wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid_i,
  input  logic [4:0]      alu_rd_i,
  input  logic [XLEN-1:0] alu_data_i,
  input  logic            ll_valid_i,
  output logic            ll_ready_o,
  input  logic [4:0]      ll_rd_i,
  input  logic [XLEN-1:0] ll_data_i,
  input  logic            iss_valid_i,
  input  logic [4:0]      iss_rd_i,
  input  logic [4:0]      rs1_id_i,
  input  logic [4:0]      rs2_id_i,
  input  logic [4:0]      rd_id_i,
  output logic            stall_o,
  output logic            w_en_o,
  output logic [4:0]      rd_id_o,
  output logic [XLEN-1:0] rd_write_data_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [XLEN-1:0] dat_q [DEPTH];
  logic [4:0]      rdm_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [31:0]     pend_q, pend_d;

  logic            alu_wr;
  logic            empty;
  logic            xfer;
  logic            pop;
  logic            push;
  logic            byp;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_dat;
  logic            clr_en;
  logic [4:0]      clr_idx;

  assign head_rd  = rdm_q[rd_ptr_q];
  assign head_dat = dat_q[rd_ptr_q];

  always_comb begin
    alu_wr     = alu_valid_i && (alu_rd_i != 5'd0);
    empty      = (count_q == '0);
    ll_ready_o = (count_q != FULL);
    xfer       = ll_valid_i && ll_ready_o;
    pop        = !alu_wr && !empty;
`ifdef WB_BYPASS_EN
    byp        = xfer && empty && !alu_wr;
`else
    byp        = 1'b0;
`endif
    push       = xfer && !byp;
  end

  // Write port: ALU first, then FIFO head, then (optionally) bypass.
  always_comb begin
    w_en_o          = 1'b0;
    rd_id_o         = 5'd0;
    rd_write_data_o = '0;
    clr_en          = 1'b0;
    clr_idx         = 5'd0;
    if (rst) begin
      w_en_o = 1'b0;
    end else if (alu_wr) begin
      w_en_o          = 1'b1;
      rd_id_o         = alu_rd_i;
      rd_write_data_o = alu_data_i;
    end else if (pop) begin
      if (head_rd != 5'd0) begin
        w_en_o          = 1'b1;
        rd_id_o         = head_rd;
        rd_write_data_o = head_dat;
        clr_en          = 1'b1;
        clr_idx         = head_rd;
      end
    end else if (byp) begin
      if (ll_rd_i != 5'd0) begin
        w_en_o          = 1'b1;
        rd_id_o         = ll_rd_i;
        rd_write_data_o = ll_data_i;
        clr_en          = 1'b1;
        clr_idx         = ll_rd_i;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  // Issue set is applied after the clear so it wins on the same index.
  always_comb begin
    pend_d = pend_q;
    if (clr_en)      pend_d[clr_idx]  = 1'b0;
    if (iss_valid_i) pend_d[iss_rd_i] = 1'b1;
    pend_d[0] = 1'b0;
  end

  assign stall_o = !rst &&
    (pend_q[rs1_id_i] | pend_q[rs2_id_i] | pend_q[rd_id_i]);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pend_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      dat_q[wr_ptr_q] <= ll_data_i;
      rdm_q[wr_ptr_q] <= ll_rd_i;
    end
  end

  a_alu_pend: assert property (@(posedge clk) disable iff (rst)
    !(alu_wr && pend_q[alu_rd_i]));

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_wb_arbiter;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid_i;
  logic [4:0]  alu_rd_i;
  logic [31:0] alu_data_i;
  logic        ll_valid_i;
  logic        ll_ready_o;
  logic [4:0]  ll_rd_i;
  logic [31:0] ll_data_i;
  logic        iss_valid_i;
  logic [4:0]  iss_rd_i;
  logic [4:0]  rs1_id_i;
  logic [4:0]  rs2_id_i;
  logic [4:0]  rd_id_i;
  logic        stall_o;
  logic        w_en_o;
  logic [4:0]  rd_id_o;
  logic [31:0] rd_write_data_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  always #5 clk = ~clk;

  wb_arbiter #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .alu_valid_i(alu_valid_i),
    .alu_rd_i(alu_rd_i),
    .alu_data_i(alu_data_i),
    .ll_valid_i(ll_valid_i),
    .ll_ready_o(ll_ready_o),
    .ll_rd_i(ll_rd_i),
    .ll_data_i(ll_data_i),
    .iss_valid_i(iss_valid_i),
    .iss_rd_i(iss_rd_i),
    .rs1_id_i(rs1_id_i),
    .rs2_id_i(rs2_id_i),
    .rd_id_i(rd_id_i),
    .stall_o(stall_o),
    .w_en_o(w_en_o),
    .rd_id_o(rd_id_o),
    .rd_write_data_o(rd_write_data_o)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    alu_valid_i = 0; alu_rd_i = 0; alu_data_i = 0;
    ll_valid_i = 0; ll_rd_i = 0; ll_data_i = 0;
    iss_valid_i = 0; iss_rd_i = 0;
    rs1_id_i = 0; rs2_id_i = 0; rd_id_i = 0;
  endtask

  task automatic do_reset;
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    alu_valid_i = 1; alu_rd_i = 5; alu_data_i = 32'h1;
    ll_valid_i = 1; ll_rd_i = 6; ll_data_i = 32'h2;
    iss_valid_i = 1; iss_rd_i = 7;
    rs1_id_i = 7; rs2_id_i = 6; rd_id_i = 5;
    tick();
    @(negedge clk);
    checks++;
    if (w_en_o !== 1'b0) begin
      errors++; $display("FAIL reset_wen got %b want 0", w_en_o);
    end
    checks++;
    if (ll_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b want 1", ll_ready_o);
    end
    checks++;
    if (stall_o !== 1'b0) begin
      errors++; $display("FAIL reset_stall got %b want 0", stall_o);
    end
    tick();
    rst = 0;
    idle();
    @(negedge clk);
    checks++;
    if (w_en_o !== 1'b0) begin
      errors++; $display("FAIL reset_fifo_empty got %b want 0", w_en_o);
    end
    for (int i = 1; i < 32; i++) begin
      rs1_id_i = 5'(i);
      #1;
      checks++;
      if (stall_o !== 1'b0) begin
        errors++; $display("FAIL reset_pend x%0d got %b want 0", i, stall_o);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_priority;
    do_reset();
    alu_valid_i = 1; alu_rd_i = 5; alu_data_i = 32'h1234;
    ll_valid_i = 1; ll_rd_i = 6; ll_data_i = 32'hBEEF;
    @(negedge clk);
    checks++;
    if ({w_en_o, rd_id_o, rd_write_data_o} !== {1'b1, 5'd5, 32'h1234}) begin
      errors++;
      $display("FAIL prio_c0 got %b/%0d/%h want 1/5/1234",
               w_en_o, rd_id_o, rd_write_data_o);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if ({w_en_o, rd_id_o, rd_write_data_o} !== {1'b1, 5'd6, 32'hBEEF}) begin
      errors++;
      $display("FAIL prio_c1 got %b/%0d/%h want 1/6/beef",
               w_en_o, rd_id_o, rd_write_data_o);
    end
    tick();
  endtask

  task automatic test_stall;
    logic ew;
    logic es;
    do_reset();
    iss_valid_i = 1; iss_rd_i = 7;
    tick();
    idle();
    rs1_id_i = 7;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (stall_o !== 1'b1) begin
        errors++; $display("FAIL stall_wait%0d got %b want 1", i, stall_o);
      end
      tick();
    end
    ll_valid_i = 1; ll_rd_i = 7; ll_data_i = 32'hCAFE;
    ew = BYP;
    @(negedge clk);
    checks++;
    if (w_en_o !== ew || stall_o !== 1'b1) begin
      errors++;
      $display("FAIL stall_xfer got w%b s%b want w%b s1", w_en_o, stall_o, ew);
    end
    tick();
    ll_valid_i = 0;
    ew = !BYP;
    es = !BYP;
    @(negedge clk);
    checks++;
    if (w_en_o !== ew || stall_o !== es) begin
      errors++;
      $display("FAIL stall_write got w%b s%b want w%b s%b",
               w_en_o, stall_o, ew, es);
    end
    tick();
    @(negedge clk);
    checks++;
    if (stall_o !== 1'b0) begin
      errors++; $display("FAIL stall_clear got %b want 0", stall_o);
    end
    tick();
  endtask

  task automatic test_full;
    do_reset();
    alu_valid_i = 1; alu_rd_i = 1; alu_data_i = 32'h11;
    for (int i = 0; i < DEPTH; i++) begin
      ll_valid_i = 1; ll_rd_i = 5'(10 + i); ll_data_i = 32'hA0 + i;
      @(negedge clk);
      checks++;
      if (ll_ready_o !== 1'b1) begin
        errors++; $display("FAIL full_push%0d got %b want 1", i, ll_ready_o);
      end
      tick();
    end
    ll_rd_i = 5'd20;
    @(negedge clk);
    checks++;
    if (ll_ready_o !== 1'b0) begin
      errors++; $display("FAIL full_ready got %b want 0", ll_ready_o);
    end
    tick();
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      checks++;
      if ({w_en_o, rd_id_o, rd_write_data_o} !==
          {1'b1, 5'(10 + i), 32'hA0 + i}) begin
        errors++;
        $display("FAIL full_drain%0d got %b/%0d/%h", i,
                 w_en_o, rd_id_o, rd_write_data_o);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (w_en_o !== 1'b0 || ll_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL full_empty got w%b r%b want w0 r1", w_en_o, ll_ready_o);
    end
    tick();
  endtask

  task automatic test_same_cycle;
    do_reset();
    iss_valid_i = 1; iss_rd_i = 9;
    tick();
    idle();
    alu_valid_i = 1; alu_rd_i = 1; alu_data_i = 32'h5;
    ll_valid_i = 1; ll_rd_i = 9; ll_data_i = 32'h99;
    tick();
    idle();
    iss_valid_i = 1; iss_rd_i = 9;
    @(negedge clk);
    checks++;
    if ({w_en_o, rd_id_o, rd_write_data_o} !== {1'b1, 5'd9, 32'h99}) begin
      errors++;
      $display("FAIL same_pop got %b/%0d/%h want 1/9/99",
               w_en_o, rd_id_o, rd_write_data_o);
    end
    tick();
    idle();
    rs2_id_i = 9;
    alu_valid_i = 1; alu_rd_i = 1; alu_data_i = 32'h6;
    ll_valid_i = 1; ll_rd_i = 0; ll_data_i = 32'h77;
    @(negedge clk);
    checks++;
    if (stall_o !== 1'b1) begin
      errors++; $display("FAIL same_setwins got %b want 1", stall_o);
    end
    tick();
    idle();
    rs2_id_i = 9;
    @(negedge clk);
    checks++;
    if (w_en_o !== 1'b0) begin
      errors++; $display("FAIL x0_drop got %b want 0", w_en_o);
    end
    tick();
    @(negedge clk);
    checks++;
    if (w_en_o !== 1'b0 || stall_o !== 1'b1) begin
      errors++;
      $display("FAIL x0_gone got w%b s%b want w0 s1", w_en_o, stall_o);
    end
    tick();
  endtask

  task automatic test_bypass;
    logic ew;
    do_reset();
    ll_valid_i = 1; ll_rd_i = 3; ll_data_i = 32'h55;
    ew = BYP;
    @(negedge clk);
    checks++;
    if (w_en_o !== ew || rd_id_o !== (ew ? 5'd3 : 5'd0)) begin
      errors++;
      $display("FAIL byp_c0 got %b/%0d want %b", w_en_o, rd_id_o, ew);
    end
    tick();
    idle();
    ew = !BYP;
    @(negedge clk);
    checks++;
    if (w_en_o !== ew || rd_id_o !== (ew ? 5'd3 : 5'd0)) begin
      errors++;
      $display("FAIL byp_c1 got %b/%0d want %b", w_en_o, rd_id_o, ew);
    end
    tick();
  endtask

  task automatic test_random;
    ent_t        mq[$];
    ent_t        e;
    logic [31:0] mpend;
    logic        ealu, epop, ebyp, ew, er, es;
    logic [4:0]  erd;
    logic [31:0] ed;
    do_reset();
    mpend = 0;
    for (int c = 0; c < 600; c++) begin
      alu_valid_i = ($urandom_range(0, 99) < 40);
      alu_rd_i    = 5'($urandom_range(0, 31));
      if (mpend[alu_rd_i]) alu_rd_i = 0;
      alu_data_i  = $urandom;
      ll_valid_i  = ($urandom_range(0, 99) < 55);
      ll_rd_i     = 5'($urandom_range(0, 31));
      ll_data_i   = $urandom;
      iss_valid_i = ($urandom_range(0, 99) < 30);
      iss_rd_i    = 5'($urandom_range(0, 31));
      rs1_id_i    = 5'($urandom_range(0, 31));
      rs2_id_i    = 5'($urandom_range(0, 31));
      rd_id_i     = 5'($urandom_range(0, 31));

      er   = (mq.size() != DEPTH);
      ealu = alu_valid_i && alu_rd_i != 0;
      epop = !ealu && mq.size() > 0;
      ebyp = BYP && ll_valid_i && mq.size() == 0 && !ealu;
      ew = 0; erd = 0; ed = 0;
      if (ealu) begin
        ew = 1; erd = alu_rd_i; ed = alu_data_i;
      end else if (epop) begin
        ew = (mq[0].rd != 0); erd = mq[0].rd; ed = mq[0].d;
      end else if (ebyp) begin
        ew = (ll_rd_i != 0); erd = ll_rd_i; ed = ll_data_i;
      end
      es = mpend[rs1_id_i] | mpend[rs2_id_i] | mpend[rd_id_i];

      @(negedge clk);
      checks++;
      if (ll_ready_o !== er) begin
        errors++; $display("FAIL rnd_ready c%0d got %b want %b", c, ll_ready_o, er);
      end
      checks++;
      if (w_en_o !== ew) begin
        errors++; $display("FAIL rnd_wen c%0d got %b want %b", c, w_en_o, ew);
      end
      checks++;
      if (ew && (rd_id_o !== erd || rd_write_data_o !== ed)) begin
        errors++;
        $display("FAIL rnd_wdata c%0d got %0d/%h want %0d/%h",
                 c, rd_id_o, rd_write_data_o, erd, ed);
      end
      checks++;
      if (stall_o !== es) begin
        errors++; $display("FAIL rnd_stall c%0d got %b want %b", c, stall_o, es);
      end

      @(posedge clk);
      if (epop) void'(mq.pop_front());
      if ((epop || ebyp) && ew) mpend[erd] = 1'b0;
      if (ll_valid_i && er && !ebyp) begin
        e.rd = ll_rd_i; e.d = ll_data_i;
        mq.push_back(e);
      end
      if (iss_valid_i) mpend[iss_rd_i] = 1'b1;
      mpend[0] = 1'b0;
      #1;
    end
    idle();
  endtask

  initial begin
    idle();
    rst = 1;
    test_reset();
    test_priority();
    test_stall();
    test_full();
    test_same_cycle();
    test_bypass();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
